// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter FSM states, command bytes and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESEND   = 8'hFE;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchroniser for the PS/2 clock and data lines plus a registered clock falling-edge strobe.
// Shared between the host transmitter and the keyboard receiver.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sr   <= '1;
      dat_sr   <= '1;
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_sr[0] <= clk_in;
      dat_sr[0] <= dat_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clk_sr[i] <= clk_sr[i-1];
        dat_sr[i] <= dat_sr[i-1];
      end
      clk_prev <= clk_sync;
      clk_fall <= clk_prev & ~clk_sync;
    end
  end

  assign clk_sync = clk_sr[SYNC_STAGES-1];
  assign dat_sync = dat_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ack.
// Optional PS2_TX_RETRY_EN: retry a failed byte from INHIBIT up to 2 times before flagging error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       error,
  output logic       busy
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state, state_nx;
  logic             clk_sync, dat_sync, clk_fall;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       cmd_byte;
  logic             parity;
  logic [2:0]       bit_cnt;
  logic             dat_drv;
  logic             in_frame, tmo_hit, nack, ack_ok, fail, give_up;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_cnt;
  logic             retry;
`endif

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  assign in_frame = state inside {DATA, PARITY, STOP, ACK};
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);
  assign nack     = (state == ACK) && clk_fall && !tmo_hit && dat_sync;
  assign ack_ok   = (state == ACK) && clk_fall && !tmo_hit && !dat_sync;
  assign fail     = tmo_hit || nack;
`ifdef PS2_TX_RETRY_EN
  assign retry    = fail && (retry_cnt != 2'd2);
  assign give_up  = fail && !retry;
`else
  assign give_up  = fail;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cmd_valid) state_nx = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) state_nx = RTS;
      RTS:       state_nx = DATA;
      DATA:      if (clk_fall && bit_cnt == 3'd7) state_nx = PARITY;
      PARITY:    if (clk_fall) state_nx = STOP;
      STOP:      if (clk_fall) state_nx = ACK;
      ACK:       if (clk_fall) state_nx = WAIT_IDLE;
      WAIT_IDLE: if (clk_sync && dat_sync) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    // Timeout skips WAIT_IDLE and beats a falling edge in the same cycle.
    if (tmo_hit) state_nx = IDLE;
`ifdef PS2_TX_RETRY_EN
    if (retry) state_nx = INHIBIT;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      cmd_byte  <= '0;
      parity    <= 1'b0;
      bit_cnt   <= '0;
      dat_drv   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      done    <= ack_ok;
      error   <= give_up;
      inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      tmo_cnt <= in_frame ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE && cmd_valid) begin
        cmd_byte <= cmd_data;
        parity   <= odd_parity(cmd_data);
`ifdef PS2_TX_RETRY_EN
        retry_cnt <= '0;
`endif
      end
      // Start bit is held from RTS until the first device clock edge.
      if (state == RTS) begin
        bit_cnt <= '0;
        dat_drv <= 1'b1;
      end else if (clk_fall) begin
        case (state)
          DATA: begin
            dat_drv <= ~cmd_byte[bit_cnt];
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  dat_drv <= ~parity;
          STOP:    dat_drv <= 1'b0;
          default: ;
        endcase
      end
`ifdef PS2_TX_RETRY_EN
      if (retry) retry_cnt <= retry_cnt + 1'b1;
`endif
    end
  end

  always_comb begin
    cmd_ready  = (state == IDLE);
    busy       = (state != IDLE);
    ps2_clk_oe = (state == INHIBIT) || (state == RTS);
    ps2_dat_oe = (state == RTS) || (in_frame && dat_drv);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a frame/timing model checks it.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 600;
  localparam int          HALF = 8;
  localparam int DEV_ACK = 0, DEV_NACK = 1, DEV_SILENT = 2;
  localparam int EXP_DONE = 0, EXP_NACK = 1, EXP_TMO = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       cmd_ready, done, error, busy;

  // Open-collector wired-AND of host and device drivers.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .done       (done),
    .error      (error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          vectors = 0, miscompares = 0;
  bit          m_active = 1'b0, m_finished = 1'b0;
  int          m_acc = 0;
  int          m_expect = EXP_DONE;
  logic [10:0] dev_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line levels seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle check against the transfer timeline relative to the accept edge.
  always @(negedge clock) begin
    int k;
    if (!reset) begin
      check("ready_vs_busy", cmd_ready, !busy);
      check("done_error_exclusive", done & error, 0);
      k = cyc - m_acc;
      if (!m_active || m_finished) begin
        if (done || error) check("spurious_pulse", {done, error}, 0);
      end else if (done || error) begin
        m_finished = 1'b1;
        check("done", done, m_expect == EXP_DONE);
        check("error", error, m_expect != EXP_DONE);
        check("busy_at_pulse", busy, m_expect != EXP_TMO);
        check("lines_at_pulse", {ps2_clk_oe, ps2_dat_oe}, 0);
        if (m_expect == EXP_TMO) check("timeout_latency", k, INH + 1 + TMO);
      end else if (k < 0) begin
        check("ready_before_accept", cmd_ready, 1);
      end else begin
        check("busy", busy, 1);
        check("clk_oe", ps2_clk_oe, k <= INH);
        if (k <= INH + 1) check("dat_oe_rts", ps2_dat_oe, k >= INH);
      end
    end
  end

  task automatic device(input int mode, input int n_edges);
    int n;
    dev_frame = '0;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin @(negedge clock); n++; end
    check("dev_saw_inhibit", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe && n < INH + 20) begin @(negedge clock); n++; end
    check("dev_saw_release", ps2_clk_oe, 0);
    if (mode == DEV_SILENT) return;
    repeat (4) @(negedge clock);
    dev_frame[0] = ps2_dat_in;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_dat = (mode == DEV_NACK);
      repeat (HALF) @(negedge clock);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      if (e <= 10) dev_frame[e] = ps2_dat_in;
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clock);
    dev_dat = 1'b1;
  endtask

  // Call at posedge+2 with cmd_ready high; the accept lands on the next edge.
  task automatic run_txn(input logic [7:0] b, input int mode, input int n_edges, input bit keep_valid);
    cmd_data   = b;
    cmd_valid  = 1'b1;
    m_acc      = cyc + 1;
    m_finished = 1'b0;
    m_active   = 1'b1;
    m_expect   = (mode == DEV_ACK) ? EXP_DONE : (mode == DEV_NACK) ? EXP_NACK : EXP_TMO;
    fork
      device(mode, n_edges);
      begin
        @(posedge clock);
        #2;
        if (!keep_valid) cmd_valid = 1'b0;
      end
    join
    if (n_edges == 11 || mode == DEV_SILENT) begin
      for (int n = 0; n < int'(TMO) + 100 && !m_finished; n++) @(posedge clock);
      check("outcome_pulse_seen", m_finished, 1);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(posedge clock);
    #2;
    while (!cmd_ready && n < 200) begin
      @(posedge clock);
      #2;
      n++;
    end
    check("return_to_idle", cmd_ready, 1);
    check("idle_lines", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [10:0] exp_f;
    int          mode;

    repeat (3) @(posedge clock);
    #2;
    check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, done, error, busy}, 0);
    reset = 1'b0;
    @(posedge clock);
    #2;
    check("ready_after_reset", cmd_ready, 1);

    run_txn(CMD_RESET, DEV_ACK, 11, 1'b0);
    check("frame_ff", dev_frame, 11'h7FE);
    wait_ready();

    run_txn(CMD_SET_LEDS, DEV_ACK, 11, 1'b0);
    check("frame_ed", dev_frame, 11'h7DA);
    wait_ready();

    run_txn(8'h01, DEV_NACK, 11, 1'b0);
    check("frame_01", dev_frame, 11'h402);
    wait_ready();

    run_txn(8'h5A, DEV_SILENT, 11, 1'b0);
    wait_ready();

    // Reset after the device's 5th clock, with bit 4 on the line.
    b = 8'($urandom);
    run_txn(b, DEV_ACK, 5, 1'b0);
    exp_f = model_frame(b);
    check("partial_frame", dev_frame[5:0], exp_f[5:0]);
    @(posedge clock);
    #2;
    check("busy_mid_data", busy, 1);
    m_active = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_mid_release", {ps2_clk_oe, ps2_dat_oe, busy}, 0);
    @(negedge clock);
    check("reset_mid_next", {ps2_clk_oe, ps2_dat_oe, busy, done, error}, 0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    wait_ready();
    run_txn(8'h00, DEV_ACK, 11, 1'b0);
    check("frame_00", dev_frame, 11'h600);
    wait_ready();

    // cmd_valid held across a transfer, then a second byte after IDLE.
    run_txn(CMD_SET_LEDS, DEV_ACK, 11, 1'b1);
    check("frame_hold", dev_frame, 11'h7DA);
    wait_ready();
    run_txn(CMD_RESEND, DEV_ACK, 11, 1'b0);
    check("frame_resend", dev_frame, model_frame(CMD_RESEND));
    wait_ready();

    for (int i = 0; i < 10; i++) begin
      b    = 8'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? DEV_NACK : DEV_ACK;
      run_txn(b, mode, 11, 1'b0);
      check("frame_random", dev_frame, model_frame(b));
      wait_ready();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It is the sending end of the PS/2 link that the keyboard receiver listens on. It takes one command byte, such as 0xFF (reset) or 0xED (set LEDs), and runs the full host-to-device sequence: inhibit, request-to-send, 8 data bits, odd parity, stop, then the device's acknowledge. It drives PS2_CLK/PS2_DAT open-collector through output-enable pins; the top level ties the tristates and shares the input lines with the receiver.

Parameters:
INHIBIT_CYCLES, 6000, clock cycles PS2_CLK is held low before request-to-send (120 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max cycles from clock release to ack (15 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop stages synchronising ps2_clk_in/ps2_dat_in.

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  asynchronous, active-high reset
cmd_data  in  8  byte to send
cmd_valid  in  1  request; accepted when cmd_valid & cmd_ready
cmd_ready  out  1  high only in IDLE
ps2_clk_in  in  1  sampled PS2_CLK line
ps2_dat_in  in  1  sampled PS2_DAT line
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_dat_oe  out  1  1 = pull PS2_DAT low
done  out  1  one-cycle pulse, byte acknowledged
error  out  1  one-cycle pulse, no ack or timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all counters 0; ps2_clk_oe=0, ps2_dat_oe=0 (lines released); done=0, error=0, busy=0; cmd_ready=1 after reset deasserts. Reset mid-transfer releases both lines at once, with no partial frame completion.
- Falling-edge detect: a falling edge is synchronised clk, previous 1, current 0. Edges are ignored in IDLE, INHIBIT and RTS.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_data into shift register and compute parity = ~^cmd_data (odd).
  - Go to INHIBIT next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: one cycle with ps2_clk_oe=1 and ps2_dat_oe=1 (start bit 0). Next cycle ps2_clk_oe=0, ps2_dat_oe stays 1; go to DATA. Timeout counter cleared.
- DATA:
  - On each falling edge, drive the next bit, LSB first: ps2_dat_oe = ~bit.
  - Bit counter 0..7; after the 8th edge go to PARITY.
- PARITY: on next falling edge, ps2_dat_oe = ~parity; go to STOP.
- STOP: on next falling edge, ps2_dat_oe=0 (stop bit 1, line released); go to ACK.
- ACK: on next falling edge (11th after release), sample synchronised data.
  - 0: pulse done, go to WAIT_IDLE.
  - 1: pulse error, go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clk=1 and dat=1, then IDLE.
- Timeout:
  - Counter runs from RTS exit through ACK.
  - Reaching TIMEOUT_CYCLES-1: release both lines, pulse error, go to IDLE directly (skip WAIT_IDLE).
  - Timeout wins over a simultaneous falling edge.
- cmd_valid while busy is ignored (not queued). done and error are never both high.
- Latency: command accept to ps2_clk_oe=1 is 1 cycle.

Optional Feature:
PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, restart from INHIBIT with the latched byte, up to 2 retries. error pulses only after the 3rd failure; done pulses on any success.
- Undefined: a single attempt; the first failure pulses error.

Decomposition:
- Package ps2_pkg holds:
  - state enum (IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE)
  - command constants: CMD_RESET 8'hFF, CMD_SET_LEDS 8'hED, CMD_RESEND 8'hFE
  - ACK_BYTE 8'hFA
- Sub-module ps2_sync_edge: SYNC_STAGES synchroniser on clk/dat plus a registered clk falling-edge strobe. It is shared with the receiver.

Test Plan:
- Send 0xFF; device model acks: after INHIBIT_CYCLES low, dat_oe bits 1..1 give oe=0 ×8, parity 1 gives oe=0, stop; done pulses once, error=0.
- Send 0xED: data oe sequence LSB-first is 0,1,0,0,1,0,0,0; parity 1 → oe 0; done.
- Send 0x01 with model holding dat high at the ack edge: parity 0 → oe 1; error pulse, done=0, returns to IDLE after lines high.
- Device model never clocks: ps2_clk_oe released at INHIBIT_CYCLES+1; error at TIMEOUT_CYCLES after release; both oe=0.
- Assert reset during DATA at bit 4: next cycle both oe=0, busy=0; a fresh 0x00 then completes with done.
- cmd_valid held high across a whole transfer: exactly one byte sent; second accept only after IDLE, cmd_ready=1.
